fetch_ip_gen: RTL and testbench
===============================

# fetch_ip_gen

Fetch-stage next-IP generator with a direct-mapped branch target buffer (BTB). Each cycle it presents `IP_f` to the instruction memory and to the direction predictor, combines the predictor's `prediction` with a BTB lookup to choose the next fetch IP, and redirects fetch when execute reports a misprediction. Execute-stage resolutions also train the BTB and two saturating performance counters.

## Interface
- `BTB_IDX`, 6: log2 of BTB entry count; index = `IP[BTB_IDX-1:0]`.
- `TAG_BITS`, 16-BTB_IDX: tag width; tag = `IP[15:BTB_IDX]`.
- `RESET_IP`, 16'h0000: fetch IP after reset.

Ports:
- `CLOCK_50`  in  1  sole clock, rising edge.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hold `IP_f` this cycle.
- `prediction`  in  1  predicted direction for the current `IP_f`, valid in the same cycle.
- `resolveValid`  in  1  execute resolves one instruction this cycle.
- `resolveIP`  in  16  IP of the resolved instruction.
- `resolveWasJump`  in  1  resolved instruction is a conditional jump.
- `resolveDidJump`  in  1  jump was taken.
- `resolveTarget`  in  16  taken-target IP.
- `resolveMispredict`  in  1  fetch went down the wrong path; redirect required.
- `IP_f`  out  16  current fetch IP.
- `predTaken_f`  out  1  BTB hit and `prediction` both high for `IP_f`.
- `flush`  out  1  `IP_f` is the first IP after a redirect; younger stages discard their contents.
- `branchCount`  out  16  resolved jumps, saturating.
- `mispredictCount`  out  16  accepted redirects, saturating.

## Operation
- BTB: 2**BTB_IDX entries, each holding {valid, tag[TAG_BITS], target[16]}. Lookup is combinational on `IP_f`. Hit = valid && tag match.
- `predTaken_f` = hit && `prediction`.
- Next-IP priority, highest first:
  - Redirect (`resolveValid && resolveMispredict`): `resolveDidJump ? resolveTarget : resolveIP + 1`.
  - `stall`: hold `IP_f`.
  - `predTaken_f`: BTB target.
  - Otherwise: `IP_f + 1`.
- A redirect overrides `stall`.
- All `+1` arithmetic is 16-bit and wraps: 16'hFFFF -> 16'h0000.
- BTB write occurs when `resolveValid && resolveWasJump && resolveDidJump`. It sets valid, the tag of `resolveIP`, and `resolveTarget` at `BTB[resolveIP[BTB_IDX-1:0]]`, replacing any previous entry. Not-taken resolutions never write or evict.
- `branchCount` increments when `resolveValid && resolveWasJump`. `mispredictCount` increments on every redirect. Both hold at 16'hFFFF.
- `resolveMispredict` without `resolveValid` is ignored.

## Timing
- Reset (asynchronous assert, synchronous release on `CLOCK_50`) sets:
  - `IP_f` = RESET_IP
  - `flush` = 0
  - both counters = 0
  - all BTB valid bits = 0
  - `predTaken_f` = 0, since no entry hits
- Reset asserted mid-redirect or mid-stall takes effect immediately and the pending event is lost.
- `IP_f` updates on the rising edge. A redirect in cycle N makes `IP_f` equal the corrected IP in cycle N+1.
- `flush` is registered: high for exactly cycle N+1 after a redirect in cycle N, low otherwise. Back-to-back redirects in N and N+1 give `flush` high in N+1 and N+2.
- BTB write and lookup at the same index in the same cycle: the lookup returns the pre-write contents, and the new entry becomes visible from N+1.
- Redirect and BTB update from the same resolution both take effect at the same edge.
- `predTaken_f` has zero-cycle latency from `IP_f` and `prediction`. It is a combinational path through the BTB read.

## Structure
- Shared package holds `IP_W` = 16 and the BTB entry struct {valid, tag, target}, parameterised via `TAG_BITS`.
- Sub-module `btb_array` contains:
  - storage with an asynchronous read port and a synchronous write port
  - valid bits cleared by `RESET_N`
  - tag/target storage that is not reset
- The top level holds the next-IP mux, `IP_f` and `flush` registers, and the counters.

## Test plan
- Reset then free-run with no resolutions -> `IP_f` = 0, 1, 2, ...; `predTaken_f` = 0; `flush` = 0.
- Start from `IP_f` = 16'hFFFE, no stall -> 16'hFFFF, then 16'h0000 (wrap).
- Resolve taken jump `resolveIP` = 16'h0040, target 16'h0100, no mispredict. Later `IP_f` = 16'h0040 with `prediction` = 1 -> `predTaken_f` = 1, next `IP_f` = 16'h0100. Repeat with `prediction` = 0 -> next `IP_f` = 16'h0041.
- Alias check: after the entry above, `IP_f` = 16'h0080 (same index, different tag) with `prediction` = 1 -> no hit, next `IP_f` = 16'h0081.
- `stall` = 1 with simultaneous mispredict (`resolveIP` = 16'h0010, not taken) -> next `IP_f` = 16'h0011; `flush` = 1 for one cycle; `mispredictCount` +1.
- Preload `mispredictCount` to 16'hFFFF via 65535 redirects, then one more -> remains 16'hFFFF. Assert `RESET_N` = 0 mid-run -> `IP_f` = RESET_IP immediately, BTB hits cleared.

Source files
------------

// File: rtl/fetch_ip_gen_pkg.sv
// fetch_ip_gen_pkg: shared widths and BTB entry layout for the fetch next-IP generator
package fetch_ip_gen_pkg;
   localparam int IP_W     = 16;
   localparam int BTB_IDX  = 6;
   localparam int TAG_BITS = IP_W - BTB_IDX;
   typedef struct packed {
      logic                valid;
      logic [TAG_BITS-1:0] tag;
      logic [IP_W-1:0]     target;
   } btb_entry_t;
endpackage

// File: rtl/fetch_ip_gen_btb_array.sv
// btb_array: direct-mapped BTB storage, async read, sync write, only valid bits reset
module btb_array
   import fetch_ip_gen_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [BTB_IDX-1:0]  rd_idx,
   output btb_entry_t          rd_entry,
   input  logic                wr_en,
   input  logic [BTB_IDX-1:0]  wr_idx,
   input  logic [TAG_BITS-1:0] wr_tag,
   input  logic [IP_W-1:0]     wr_target
);
   logic [2**BTB_IDX-1:0] valid;
   logic [TAG_BITS-1:0]   tag_mem [2**BTB_IDX];
   logic [IP_W-1:0]       tgt_mem [2**BTB_IDX];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) valid <= '0;
      else if (wr_en) valid[wr_idx] <= 1'b1;
   always_ff @(posedge clk)
      if (wr_en) begin
         tag_mem[wr_idx] <= wr_tag;
         tgt_mem[wr_idx] <= wr_target;
      end
   assign rd_entry = '{valid: valid[rd_idx], tag: tag_mem[rd_idx], target: tgt_mem[rd_idx]};
endmodule

// File: rtl/fetch_ip_gen.sv
// fetch_ip_gen: picks the next fetch IP from redirect, stall, BTB prediction or sequential
// and keeps saturating branch / mispredict counters
module fetch_ip_gen
   import fetch_ip_gen_pkg::*;
#(
   parameter logic [IP_W-1:0] RESET_IP = 16'h0000
) (
   input  logic            CLOCK_50,
   input  logic            RESET_N,
   input  logic            stall,
   input  logic            prediction,
   input  logic            resolveValid,
   input  logic [IP_W-1:0] resolveIP,
   input  logic            resolveWasJump,
   input  logic            resolveDidJump,
   input  logic [IP_W-1:0] resolveTarget,
   input  logic            resolveMispredict,
   output logic [IP_W-1:0] IP_f,
   output logic            predTaken_f,
   output logic            flush,
   output logic [15:0]     branchCount,
   output logic [15:0]     mispredictCount
);
   btb_entry_t      entry;
   logic            hit, redirect, branch, btb_wr;
   logic [IP_W-1:0] next_ip;
   btb_array u_btb (
      .clk      (CLOCK_50),
      .rst_n    (RESET_N),
      .rd_idx   (IP_f[BTB_IDX-1:0]),
      .rd_entry (entry),
      .wr_en    (btb_wr),
      .wr_idx   (resolveIP[BTB_IDX-1:0]),
      .wr_tag   (resolveIP[IP_W-1:BTB_IDX]),
      .wr_target(resolveTarget)
   );
   always_comb begin
      redirect    = resolveValid & resolveMispredict;
      branch      = resolveValid & resolveWasJump;
      btb_wr      = branch & resolveDidJump;
      hit         = entry.valid && entry.tag == IP_f[IP_W-1:BTB_IDX];
      predTaken_f = hit & prediction;
      next_ip     = redirect    ? (resolveDidJump ? resolveTarget : resolveIP + 16'd1) :
                    stall       ? IP_f :
                    predTaken_f ? entry.target : IP_f + 16'd1;
   end
   always_ff @(posedge CLOCK_50 or negedge RESET_N)
      if (!RESET_N) begin
         IP_f            <= RESET_IP;
         flush           <= 1'b0;
         branchCount     <= '0;
         mispredictCount <= '0;
      end else begin
         IP_f  <= next_ip;
         flush <= redirect;
         if (branch && branchCount != 16'hFFFF) branchCount <= branchCount + 16'd1;
         if (redirect && mispredictCount != 16'hFFFF) mispredictCount <= mispredictCount + 16'd1;
      end
endmodule

// File: tb/tb_fetch_ip_gen.sv
// tb_fetch_ip_gen: scenario tasks plus randomized traffic checked against a map-based fetch model
module tb_fetch_ip_gen;
   logic        clk = 0, rst_n = 0;
   logic        stall = 0, prediction = 0, rv = 0, wj = 0, dj = 0, rm = 0;
   logic [15:0] rip = 0, rtgt = 0;
   logic [15:0] ip_f, bc, mc;
   logic        pt, flush;
   int checks = 0, errors = 0;

   logic [15:0] m_ip, m_bc, m_mc;
   logic        m_flush;
   int          m_src [int];
   int          m_tgt [int];

   fetch_ip_gen dut (
      .CLOCK_50(clk), .RESET_N(rst_n), .stall(stall), .prediction(prediction),
      .resolveValid(rv), .resolveIP(rip), .resolveWasJump(wj), .resolveDidJump(dj),
      .resolveTarget(rtgt), .resolveMispredict(rm), .IP_f(ip_f), .predTaken_f(pt),
      .flush(flush), .branchCount(bc), .mispredictCount(mc)
   );

   always #5 clk = ~clk;

   function automatic logic m_hit(input logic [15:0] ip);
      int idx = int'(ip) % 64;
      return m_src.exists(idx) && (m_src[idx] / 64) == (int'(ip) / 64);
   endfunction

   task automatic model_reset();
      m_ip = 16'h0000; m_flush = 0; m_bc = 0; m_mc = 0;
      m_src.delete(); m_tgt.delete();
   endtask

   task automatic drive(input logic v, m, w, d, input logic [15:0] i, t);
      rv = v; rm = m; wj = w; dj = d; rip = i; rtgt = t;
   endtask

   task automatic tick();
      logic        redir, tp;
      logic [15:0] nip;
      redir = rv && rm;
      tp    = m_hit(m_ip) && prediction;
      if (redir) nip = dj ? rtgt : rip + 16'd1;
      else if (stall) nip = m_ip;
      else if (tp) nip = 16'(m_tgt[int'(m_ip) % 64]);
      else nip = m_ip + 16'd1;
      @(posedge clk);
      m_ip = nip;
      m_flush = redir;
      if (rv && wj && dj) begin
         m_src[int'(rip) % 64] = int'(rip);
         m_tgt[int'(rip) % 64] = int'(rtgt);
      end
      if (rv && wj && m_bc != 16'hFFFF) m_bc++;
      if (redir && m_mc != 16'hFFFF) m_mc++;
      @(negedge clk);
   endtask

   task automatic go_to(input logic [15:0] ip);
      stall = 0;
      drive(1, 1, 0, 1, 16'h0, ip);
      tick();
      drive(0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      prediction = 1;
      checks++; if (ip_f !== 16'h0000) begin errors++; $display("FAIL reset_ip got %h exp 0000", ip_f); end
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", flush); end
      checks++; if (bc !== 16'h0 || mc !== 16'h0) begin errors++; $display("FAIL reset_counts got %h/%h exp 0/0", bc, mc); end
      checks++; if (pt !== 1'b0) begin errors++; $display("FAIL reset_pt got %b exp 0", pt); end
      prediction = 0;
   endtask

   task automatic test_free_run();
      for (int i = 1; i <= 5; i++) begin
         tick();
         checks++; if (ip_f !== 16'(i) || pt !== 0 || flush !== 0) begin
            errors++; $display("FAIL free_run ip=%h pt=%b fl=%b exp ip=%h pt=0 fl=0", ip_f, pt, flush, 16'(i));
         end
      end
   endtask

   task automatic test_wrap();
      go_to(16'hFFFE);
      checks++; if (ip_f !== 16'hFFFE || flush !== 1) begin errors++; $display("FAIL wrap_redirect ip=%h fl=%b exp FFFE/1", ip_f, flush); end
      checks++; if (mc !== m_mc) begin errors++; $display("FAIL wrap_mcount got %h exp %h", mc, m_mc); end
      tick();
      checks++; if (ip_f !== 16'hFFFF || flush !== 0) begin errors++; $display("FAIL wrap_ffff ip=%h fl=%b exp FFFF/0", ip_f, flush); end
      tick();
      checks++; if (ip_f !== 16'h0000) begin errors++; $display("FAIL wrap_zero ip=%h exp 0000", ip_f); end
   endtask

   task automatic test_btb_hit();
      drive(1, 0, 1, 1, 16'h0040, 16'h0100);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      checks++; if (bc !== m_bc) begin errors++; $display("FAIL btb_bcount got %h exp %h", bc, m_bc); end
      go_to(16'h0040);
      prediction = 1; #1;
      checks++; if (pt !== 1) begin errors++; $display("FAIL btb_hit_pt got %b exp 1", pt); end
      tick();
      checks++; if (ip_f !== 16'h0100) begin errors++; $display("FAIL btb_hit_ip got %h exp 0100", ip_f); end
      go_to(16'h0040);
      prediction = 0; #1;
      checks++; if (pt !== 0) begin errors++; $display("FAIL btb_nopred_pt got %b exp 0", pt); end
      tick();
      checks++; if (ip_f !== 16'h0041) begin errors++; $display("FAIL btb_nopred_ip got %h exp 0041", ip_f); end
   endtask

   task automatic test_alias();
      go_to(16'h0080);
      prediction = 1; #1;
      checks++; if (pt !== 0) begin errors++; $display("FAIL alias_pt got %b exp 0", pt); end
      tick();
      prediction = 0;
      checks++; if (ip_f !== 16'h0081) begin errors++; $display("FAIL alias_ip got %h exp 0081", ip_f); end
   endtask

   task automatic test_stall_redirect();
      logic [15:0] held;
      stall = 1; tick();
      held = ip_f; tick();
      checks++; if (ip_f !== held || ip_f !== m_ip) begin errors++; $display("FAIL stall_hold got %h exp %h", ip_f, m_ip); end
      drive(1, 1, 1, 0, 16'h0010, 16'h0777);
      tick();
      drive(0, 0, 0, 0, 0, 0); stall = 0;
      checks++; if (ip_f !== 16'h0011 || flush !== 1) begin errors++; $display("FAIL stall_redirect ip=%h fl=%b exp 0011/1", ip_f, flush); end
      checks++; if (mc !== m_mc || bc !== m_bc) begin errors++; $display("FAIL stall_counts got %h/%h exp %h/%h", bc, mc, m_bc, m_mc); end
      tick();
      checks++; if (flush !== 0 || ip_f !== 16'h0012) begin errors++; $display("FAIL stall_after ip=%h fl=%b exp 0012/0", ip_f, flush); end
      drive(0, 1, 0, 1, 16'h0, 16'h0999);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      checks++; if (ip_f !== 16'h0013 || flush !== 0) begin errors++; $display("FAIL rm_without_rv ip=%h fl=%b exp 0013/0", ip_f, flush); end
   endtask

   task automatic test_same_cycle_write();
      go_to(16'h0200);
      prediction = 1;
      drive(1, 0, 1, 1, 16'h0200, 16'h0300); #1;
      checks++; if (pt !== 0) begin errors++; $display("FAIL same_cycle_pt got %b exp 0", pt); end
      tick();
      drive(0, 0, 0, 0, 0, 0);
      checks++; if (ip_f !== 16'h0201) begin errors++; $display("FAIL same_cycle_ip got %h exp 0201", ip_f); end
      go_to(16'h0200); #1;
      checks++; if (pt !== 1) begin errors++; $display("FAIL after_write_pt got %b exp 1", pt); end
      tick();
      prediction = 0;
      checks++; if (ip_f !== 16'h0300) begin errors++; $display("FAIL after_write_ip got %h exp 0300", ip_f); end
   endtask

   task automatic test_back_to_back();
      drive(1, 1, 0, 1, 0, 16'h1000); tick();
      drive(1, 1, 0, 0, 16'h2000, 0); tick();
      drive(0, 0, 0, 0, 0, 0);
      checks++; if (ip_f !== 16'h2001 || flush !== 1) begin errors++; $display("FAIL b2b_second ip=%h fl=%b exp 2001/1", ip_f, flush); end
      tick();
      checks++; if (flush !== 0) begin errors++; $display("FAIL b2b_flush_drop got %b exp 0", flush); end
   endtask

   task automatic test_random();
      int bad = 0;
      for (int i = 0; i < 400; i++) begin
         stall      = ($urandom_range(0, 4) == 0);
         prediction = ($urandom_range(0, 9) < 7);
         drive($urandom_range(0, 1), ($urandom_range(0, 4) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
               16'(($urandom_range(0, 3) << 6) | $urandom_range(0, 7)),
               16'(($urandom_range(0, 3) << 6) | $urandom_range(0, 7)));
         #1;
         checks++; if (pt !== (m_hit(m_ip) && prediction)) begin
            errors++; bad++;
            if (bad < 10) $display("FAIL rand_pt cyc=%0d got %b exp %b", i, pt, m_hit(m_ip) && prediction);
         end
         tick();
         checks++; if (ip_f !== m_ip || flush !== m_flush || bc !== m_bc || mc !== m_mc) begin
            errors++; bad++;
            if (bad < 10) $display("FAIL rand_state cyc=%0d got ip=%h fl=%b bc=%h mc=%h exp ip=%h fl=%b bc=%h mc=%h",
                                   i, ip_f, flush, bc, mc, m_ip, m_flush, m_bc, m_mc);
         end
      end
      drive(0, 0, 0, 0, 0, 0); stall = 0; prediction = 0;
   endtask

   task automatic test_saturation();
      drive(1, 1, 0, 0, 16'h0005, 0);
      while (m_mc != 16'hFFFF) tick();
      checks++; if (mc !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got %h exp FFFF", mc); end
      tick();
      drive(0, 0, 0, 0, 0, 0);
      checks++; if (mc !== 16'hFFFF || ip_f !== 16'h0006) begin errors++; $display("FAIL sat_hold mc=%h ip=%h exp FFFF/0006", mc, ip_f); end
   endtask

   task automatic test_reset_mid();
      stall = 1;
      drive(1, 1, 1, 1, 16'h0040, 16'h0100);
      #2 rst_n = 0;
      #1;
      checks++; if (ip_f !== 16'h0000 || flush !== 0 || bc !== 0 || mc !== 0) begin
         errors++; $display("FAIL reset_mid ip=%h fl=%b bc=%h mc=%h exp 0000/0/0/0", ip_f, flush, bc, mc);
      end
      model_reset();
      @(negedge clk);
      stall = 0; drive(0, 0, 0, 0, 0, 0);
      rst_n = 1;
      go_to(16'h0040);
      prediction = 1; #1;
      checks++; if (pt !== 0) begin errors++; $display("FAIL reset_btb_clear pt=%b exp 0", pt); end
      tick();
      prediction = 0;
      checks++; if (ip_f !== 16'h0041) begin errors++; $display("FAIL reset_btb_ip got %h exp 0041", ip_f); end
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1;
      test_reset();
      test_free_run();
      test_wrap();
      test_btb_hit();
      test_alias();
      test_stall_redirect();
      test_same_cycle_write();
      test_back_to_back();
      test_random();
      test_saturation();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
